// File: rtl/jtframe_sdram_arb.sv
// jtframe_sdram_arb
// Shares the single game-side SDRAM read port among N ROM requesters in the
// clk_rom domain. Grants are round-robin. Each slot keeps a one-word cache, so
// a repeated read of the same address completes without an SDRAM access. Game
// traffic is held off while downloading or loop_rst is high. A transfer that
// stalls waiting for data is aborted after TOUT cycles and then retried.
//
// Ports
//   clk_rom      SDRAM-domain clock (rising edge)
//   rst_n        synchronous active-low reset
//   downloading  ROM load in progress: no grants, caches invalidated
//   loop_rst     SDRAM controller init: no new grants
//   slot_req     level request per slot, held until slot_ok
//   slot_addr    word address per slot, slot i at [i*AW +: AW]
//   slot_ok      one-cycle pulse per slot: slot_dout valid for that slot
//   slot_dout    returned data, shared by all slots
//   sdram_req    request to SDRAM controller
//   sdram_ack    controller accepted sdram_addr
//   sdram_addr   address of the granted slot
//   data_read    SDRAM read data
//   data_rdy     data_read valid, one cycle
//   busy         FSM not idle
module jtframe_sdram_arb #(
  parameter int N    = 4,
  parameter int AW   = 22,
  parameter int TOUT = 63
) (
  input  logic            clk_rom,
  input  logic            rst_n,
  input  logic            downloading,
  input  logic            loop_rst,
  input  logic [N-1:0]    slot_req,
  input  logic [N*AW-1:0] slot_addr,
  output logic [N-1:0]    slot_ok,
  output logic [31:0]     slot_dout,
  output logic            sdram_req,
  input  logic            sdram_ack,
  output logic [AW-1:0]   sdram_addr,
  input  logic [31:0]     data_read,
  input  logic            data_rdy,
  output logic            busy
);

  localparam int OW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = $clog2(TOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_RDY
  } state_t;

  state_t state, state_nxt;

  logic [OW-1:0] owner;
  logic [OW-1:0] rr;
  logic [TW-1:0] timer;

  logic [N-1:0]  valid;
  logic [AW-1:0] tag   [N];
  logic [31:0]   cdata [N];

  logic [N-1:0]  cached;
  logic [N-1:0]  avail;
  logic          hit_en;
  logic [OW-1:0] hit_idx;
  logic          grant_en;
  logic [OW-1:0] grant_idx;
  logic [AW-1:0] grant_addr;
  logic          complete;
  logic          timeout;

  assign busy     = (state != IDLE);
  assign complete = (state == WAIT_RDY) && data_rdy && !downloading;
  assign timeout  = (state == WAIT_RDY) && (timer == TW'(TOUT - 1));

  // A slot whose slot_ok is pulsing this cycle is still seen requesting
  // because the requester only drops slot_req after sampling slot_ok; it is
  // masked so it is not served twice.
  always_comb begin
    cached = '0;
    avail  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cached[i] = valid[i] && (tag[i] == slot_addr[i*AW +: AW]);
      avail[i]  = slot_req[i] && !slot_ok[i] && !(busy && (owner == OW'(i)));
    end
  end

  // Lowest-index hit wins; a completion in the same cycle takes the shared
  // output registers, so the hit simply retries on the following cycle.
  always_comb begin
    hit_en  = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!hit_en && avail[i] && cached[i]) begin
        hit_en  = 1'b1;
        hit_idx = OW'(i);
      end
    end
    if (complete || downloading) hit_en = 1'b0;
  end

  // First missing requester at or after the round-robin pointer.
  always_comb begin
    logic        found;
    int unsigned idx;
    found     = 1'b0;
    grant_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(rr) + k) % N;
      if (!found && avail[idx] && !cached[idx]) begin
        found     = 1'b1;
        grant_idx = OW'(idx);
      end
    end
    grant_en   = found && (state == IDLE) && !downloading && !loop_rst;
    grant_addr = slot_addr[grant_idx*AW +: AW];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (grant_en) state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (downloading)    state_nxt = IDLE;
        else if (sdram_ack) state_nxt = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (downloading || data_rdy || timeout) state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_rom) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk_rom) begin
    if (!rst_n) begin
      slot_ok    <= '0;
      slot_dout  <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      valid      <= '0;
      rr         <= '0;
      owner      <= '0;
      timer      <= '0;
    end else begin
      slot_ok <= '0;

      if (grant_en) begin
        owner      <= grant_idx;
        sdram_addr <= grant_addr;
        sdram_req  <= 1'b1;
      end else if ((state == WAIT_ACK) && (sdram_ack || downloading)) begin
        sdram_req <= 1'b0;
      end

      if (state == WAIT_ACK)      timer <= '0;
      else if (state == WAIT_RDY) timer <= timer + 1'b1;

      if (complete) begin
        slot_ok[owner] <= 1'b1;
        slot_dout      <= data_read;
        valid[owner]   <= 1'b1;
        rr             <= (owner == OW'(N - 1)) ? '0 : owner + 1'b1;
      end else if (hit_en) begin
        slot_ok[hit_idx] <= 1'b1;
        slot_dout        <= cdata[hit_idx];
      end

      if (downloading) valid <= '0;
    end
  end

  // Tags and data need no reset: they are qualified by valid.
  always_ff @(posedge clk_rom) begin
    if (complete) begin
      tag[owner]   <= sdram_addr;
      cdata[owner] <= data_read;
    end
  end

endmodule

// File: tb/tb_jtframe_sdram_arb.sv
module tb_jtframe_sdram_arb;
  localparam int N    = 4;
  localparam int AW   = 22;
  localparam int TOUT = 63;

  logic            clk_rom = 1'b0;
  logic            rst_n;
  logic            downloading;
  logic            loop_rst;
  logic [N-1:0]    slot_req;
  logic [N*AW-1:0] slot_addr;
  logic [N-1:0]    slot_ok;
  logic [31:0]     slot_dout;
  logic            sdram_req;
  logic            sdram_ack;
  logic [AW-1:0]   sdram_addr;
  logic [31:0]     data_read;
  logic            data_rdy;
  logic            busy;

  logic [AW-1:0]   addr_a [N];

  int nchk  = 0;
  int nfail = 0;
  int ok_total [N] = '{default: 0};

  always #5 clk_rom = ~clk_rom;

  always_comb begin
    for (int i = 0; i < N; i++) slot_addr[i*AW +: AW] = addr_a[i];
  end

  always @(negedge clk_rom) begin
    for (int i = 0; i < N; i++) if (slot_ok[i]) ok_total[i]++;
  end

  jtframe_sdram_arb #(.N(N), .AW(AW), .TOUT(TOUT)) dut (
    .clk_rom    (clk_rom),
    .rst_n      (rst_n),
    .downloading(downloading),
    .loop_rst   (loop_rst),
    .slot_req   (slot_req),
    .slot_addr  (slot_addr),
    .slot_ok    (slot_ok),
    .slot_dout  (slot_dout),
    .sdram_req  (sdram_req),
    .sdram_ack  (sdram_ack),
    .sdram_addr (sdram_addr),
    .data_read  (data_read),
    .data_rdy   (data_rdy),
    .busy       (busy)
  );

  task automatic tick;
    @(posedge clk_rom);
    #1;
  endtask

  task automatic do_reset;
    rst_n       = 1'b0;
    downloading = 1'b0;
    loop_rst    = 1'b0;
    slot_req    = '0;
    sdram_ack   = 1'b0;
    data_read   = '0;
    data_rdy    = 1'b0;
    for (int i = 0; i < N; i++) addr_a[i] = '0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  // SDRAM controller stand-in: waits (bounded) for a request, acks it after
  // one cycle, returns data two cycles after the ack. On return the caller is
  // 1 ns past the edge that sampled data_rdy.
  task automatic serve(input logic [31:0] d, output bit got, output logic [AW-1:0] a);
    got = 1'b0;
    a   = '0;
    for (int i = 0; i < 30 && !sdram_req; i++) tick;
    got = sdram_req;
    a   = sdram_addr;
    if (!got) return;
    tick;
    sdram_ack = 1'b1;
    tick;
    sdram_ack = 1'b0;
    tick;
    tick;
    data_rdy  = 1'b1;
    data_read = d;
    tick;
    data_rdy  = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    nchk++; if (slot_ok !== 4'b0000) begin nfail++; $display("FAIL reset_slot_ok: got %b want 0000", slot_ok); end
    nchk++; if (slot_dout !== 32'h0) begin nfail++; $display("FAIL reset_slot_dout: got %h want 0", slot_dout); end
    nchk++; if (sdram_req !== 1'b0) begin nfail++; $display("FAIL reset_sdram_req: got %b want 0", sdram_req); end
    nchk++; if (sdram_addr !== '0) begin nfail++; $display("FAIL reset_sdram_addr: got %h want 0", sdram_addr); end
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_miss;
    bit got;
    logic [AW-1:0] a;
    do_reset;
    addr_a[0] = 22'h000100;
    addr_a[2] = 22'h000200;
    slot_req  = 4'b0101;
    tick;
    nchk++; if (sdram_req !== 1'b1) begin nfail++; $display("FAIL miss_grant0_req: got %b want 1", sdram_req); end
    nchk++; if (sdram_addr !== 22'h000100) begin nfail++; $display("FAIL miss_grant0_addr: got %h want 000100", sdram_addr); end
    nchk++; if (busy !== 1'b1) begin nfail++; $display("FAIL miss_busy: got %b want 1", busy); end
    serve(32'hDEADBEEF, got, a);
    nchk++; if (slot_ok !== 4'b0001) begin nfail++; $display("FAIL miss_ok0: got %b want 0001", slot_ok); end
    nchk++; if (slot_dout !== 32'hDEADBEEF) begin nfail++; $display("FAIL miss_dout0: got %h want deadbeef", slot_dout); end
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL miss_idle: got %b want 0", busy); end
    slot_req = 4'b0100;
    tick;
    nchk++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h000200) begin nfail++; $display("FAIL miss_grant2: req %b addr %h want 1 000200", sdram_req, sdram_addr); end
    nchk++; if (slot_ok !== 4'b0000) begin nfail++; $display("FAIL miss_no_ok: got %b want 0000", slot_ok); end
    serve(32'h22222222, got, a);
    nchk++; if (slot_ok !== 4'b0100 || slot_dout !== 32'h22222222) begin nfail++; $display("FAIL miss_ok2: ok %b dout %h want 0100 22222222", slot_ok, slot_dout); end
    slot_req = '0;
    tick;
  endtask

  task automatic test_hit;
    bit got;
    logic [AW-1:0] a;
    do_reset;
    addr_a[1] = 22'h003333;
    slot_req  = 4'b0010;
    serve(32'h11110001, got, a);
    nchk++; if (!got || a !== 22'h003333) begin nfail++; $display("FAIL hit_fill: got %b addr %h want 1 003333", got, a); end
    nchk++; if (slot_ok !== 4'b0010) begin nfail++; $display("FAIL hit_fill_ok: got %b want 0010", slot_ok); end
    slot_req = '0;
    tick;
    tick;
    slot_req = 4'b0010;
    tick;
    nchk++; if (slot_ok !== 4'b0010 || slot_dout !== 32'h11110001) begin nfail++; $display("FAIL hit_ok: ok %b dout %h want 0010 11110001", slot_ok, slot_dout); end
    nchk++; if (sdram_req !== 1'b0 || busy !== 1'b0) begin nfail++; $display("FAIL hit_no_sdram: req %b busy %b want 0 0", sdram_req, busy); end
    slot_req = '0;
    tick;
    nchk++; if (slot_ok !== 4'b0000) begin nfail++; $display("FAIL hit_single_pulse: got %b want 0000", slot_ok); end
    // Hit arriving in the same cycle as a completion is served one cycle later.
    addr_a[2] = 22'h004444;
    slot_req  = 4'b0100;
    tick;
    nchk++; if (sdram_req !== 1'b1) begin nfail++; $display("FAIL coll_grant: got %b want 1", sdram_req); end
    sdram_ack = 1'b1;
    tick;
    sdram_ack = 1'b0;
    data_rdy  = 1'b1;
    data_read = 32'h00000055;
    slot_req  = 4'b0110;
    tick;
    data_rdy  = 1'b0;
    nchk++; if (slot_ok !== 4'b0100 || slot_dout !== 32'h00000055) begin nfail++; $display("FAIL coll_first: ok %b dout %h want 0100 00000055", slot_ok, slot_dout); end
    slot_req = 4'b0010;
    tick;
    nchk++; if (slot_ok !== 4'b0010 || slot_dout !== 32'h11110001) begin nfail++; $display("FAIL coll_second: ok %b dout %h want 0010 11110001", slot_ok, slot_dout); end
    slot_req = '0;
    tick;
  endtask

  task automatic test_round_robin;
    bit got;
    logic [AW-1:0] a;
    logic [AW-1:0] want_addr;
    int base [N];
    int exp;
    do_reset;
    for (int i = 0; i < N; i++) begin
      addr_a[i] = AW'(32'h1000 + i);
      base[i]   = ok_total[i];
    end
    slot_req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      exp       = r % N;
      want_addr = addr_a[exp];
      serve(32'hA0000000 + 32'(r), got, a);
      nchk++; if (!got || a !== want_addr) begin nfail++; $display("FAIL rr_grant%0d: got %b addr %h want 1 %h", r, got, a, want_addr); end
      nchk++; if (slot_ok !== 4'(1 << exp)) begin nfail++; $display("FAIL rr_ok%0d: got %b want %b", r, slot_ok, 4'(1 << exp)); end
      addr_a[exp] = AW'(32'h2000 + r);
    end
    slot_req = '0;
    tick;
    for (int i = 0; i < N; i++) begin
      nchk++; if (ok_total[i] - base[i] !== ((i == 0) ? 2 : 1)) begin nfail++; $display("FAIL rr_count%0d: got %0d want %0d", i, ok_total[i] - base[i], (i == 0) ? 2 : 1); end
    end
  endtask

  task automatic test_timeout;
    bit got;
    logic [AW-1:0] a;
    int cnt;
    int base;
    do_reset;
    addr_a[3] = 22'h003F00;
    slot_req  = 4'b1000;
    tick;
    nchk++; if (sdram_req !== 1'b1) begin nfail++; $display("FAIL tout_grant: got %b want 1", sdram_req); end
    base      = ok_total[3];
    sdram_ack = 1'b1;
    tick;
    sdram_ack = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      cnt++;
      if (!busy) break;
    end
    nchk++; if (cnt !== TOUT) begin nfail++; $display("FAIL tout_cycles: got %0d want %0d", cnt, TOUT); end
    nchk++; if (slot_ok !== 4'b0000) begin nfail++; $display("FAIL tout_no_ok: got %b want 0000", slot_ok); end
    tick;
    nchk++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h003F00) begin nfail++; $display("FAIL tout_retry: req %b addr %h want 1 003f00", sdram_req, sdram_addr); end
    nchk++; if (ok_total[3] !== base) begin nfail++; $display("FAIL tout_ok_count: got %0d want %0d", ok_total[3], base); end
    serve(32'h00000077, got, a);
    nchk++; if (slot_ok !== 4'b1000 || slot_dout !== 32'h00000077) begin nfail++; $display("FAIL tout_retry_ok: ok %b dout %h want 1000 00000077", slot_ok, slot_dout); end
    slot_req = '0;
    tick;
  endtask

  task automatic test_download;
    bit got;
    logic [AW-1:0] a;
    do_reset;
    addr_a[1] = 22'h005000;
    slot_req  = 4'b0010;
    serve(32'h55555555, got, a);
    nchk++; if (slot_ok !== 4'b0010) begin nfail++; $display("FAIL dl_fill: got %b want 0010", slot_ok); end
    addr_a[2] = 22'h006000;
    slot_req  = 4'b0100;
    tick;
    nchk++; if (sdram_req !== 1'b1) begin nfail++; $display("FAIL dl_grant: got %b want 1", sdram_req); end
    sdram_ack = 1'b1;
    tick;
    sdram_ack = 1'b0;
    nchk++; if (busy !== 1'b1 || sdram_req !== 1'b0) begin nfail++; $display("FAIL dl_wait_rdy: busy %b req %b want 1 0", busy, sdram_req); end
    downloading = 1'b1;
    tick;
    nchk++; if (busy !== 1'b0 || slot_ok !== 4'b0000) begin nfail++; $display("FAIL dl_abort: busy %b ok %b want 0 0000", busy, slot_ok); end
    data_rdy  = 1'b1;
    data_read = 32'h00000066;
    tick;
    data_rdy = 1'b0;
    nchk++; if (slot_ok !== 4'b0000 || sdram_req !== 1'b0) begin nfail++; $display("FAIL dl_discard: ok %b req %b want 0000 0", slot_ok, sdram_req); end
    downloading = 1'b0;
    slot_req    = '0;
    tick;
    slot_req = 4'b0010;
    tick;
    nchk++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h005000) begin nfail++; $display("FAIL dl_refetch: req %b addr %h want 1 005000", sdram_req, sdram_addr); end
    nchk++; if (slot_ok !== 4'b0000) begin nfail++; $display("FAIL dl_no_hit: got %b want 0000", slot_ok); end
    slot_req = '0;
  endtask

  task automatic test_reset_wait_ack;
    bit got;
    logic [AW-1:0] a;
    do_reset;
    addr_a[0] = 22'h007000;
    slot_req  = 4'b0001;
    serve(32'h00000070, got, a);
    nchk++; if (slot_ok !== 4'b0001) begin nfail++; $display("FAIL rst_fill: got %b want 0001", slot_ok); end
    addr_a[1] = 22'h007100;
    slot_req  = 4'b0010;
    tick;
    nchk++; if (sdram_req !== 1'b1) begin nfail++; $display("FAIL rst_grant: got %b want 1", sdram_req); end
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    nchk++; if (sdram_req !== 1'b0 || slot_ok !== 4'b0000 || busy !== 1'b0) begin nfail++; $display("FAIL rst_wait_ack: req %b ok %b busy %b want 0 0000 0", sdram_req, slot_ok, busy); end
    slot_req = 4'b0001;
    tick;
    nchk++; if (sdram_req !== 1'b1 || sdram_addr !== 22'h007000 || slot_ok !== 4'b0000) begin nfail++; $display("FAIL rst_cache_empty: req %b addr %h ok %b want 1 007000 0000", sdram_req, sdram_addr, slot_ok); end
    slot_req = '0;
  endtask

  task automatic test_loop_rst;
    bit got;
    logic [AW-1:0] a;
    do_reset;
    addr_a[0] = 22'h008000;
    loop_rst  = 1'b1;
    slot_req  = 4'b0001;
    tick;
    tick;
    tick;
    nchk++; if (sdram_req !== 1'b0 || busy !== 1'b0) begin nfail++; $display("FAIL lrst_block: req %b busy %b want 0 0", sdram_req, busy); end
    loop_rst = 1'b0;
    tick;
    loop_rst = 1'b1;
    serve(32'h00000088, got, a);
    nchk++; if (slot_ok !== 4'b0001 || slot_dout !== 32'h00000088) begin nfail++; $display("FAIL lrst_inflight: ok %b dout %h want 0001 00000088", slot_ok, slot_dout); end
    slot_req = '0;
    loop_rst = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_miss;
    test_hit;
    test_round_robin;
    test_timeout;
    test_download;
    test_reset_wait_ack;
    test_loop_rst;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
